mem_serial_responder: RTL and testbench

- Memory-side end of the 2-bit serial bus driven by the CPU scheduler.
- Deserializes TX messages (header, address, optional write data) from the CPU's tx pins and performs byte accesses on a simple synchronous memory port.
- For READ_16, serializes the 16-bit result back on the rx pins as an RX message.
- Used as the bus model in the CPU testbench and as the front end of the on-board memory bridge.

---
 rtl/mem_serial_responder.sv | 215 +++++++++++++++++++++
 tb/tb_mem_serial_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_serial_responder.sv
`timescale 1ns/1ps
// mem_serial_responder
//
// Memory-side end of the 2-bit CPU serial bus. Deserializes TX messages
// (start, header, address, optional write data) arriving on tx_pins, performs
// byte accesses on a simple synchronous memory port, and for READ_16 returns
// the 16-bit result on rx_pins as an RX message (start pair 01, then eight
// data pairs, LSB pair first). Line idle is 00 in both directions.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high
//   tx_pins        CPU -> memory serial pair
//   rx_pins        memory -> CPU serial pair
//   mem_addr       byte address (holds its last value outside accesses)
//   mem_wdata      write byte (holds its last value outside writes)
//   mem_we         write strobe, one byte per cycle
//   mem_re         read strobe; mem_rdata is valid in the following cycle
//   mem_rdata      read byte
//   busy           high in every state other than IDLE
//   protocol_error sticky error flag, cleared only by reset
//
// Parameters:
//   ADDR_BITS   address width, shifted in ADDR_BITS/2 cycles
//   NSHIFT      bits per bus cycle (only 2 is supported)
//   RESP_DELAY  extra idle cycles before the RX start cycle (0..15)
module mem_serial_responder #(
    parameter int ADDR_BITS  = 16,
    parameter int NSHIFT     = 2,
    parameter int RESP_DELAY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           tx_pins,
    output logic [1:0]           rx_pins,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 protocol_error
);

    localparam logic [7:0]           ADDR_LAST = 8'(ADDR_BITS / NSHIFT - 1);
    localparam logic [7:0]           WAIT_LAST = 8'(RESP_DELAY);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    typedef enum logic [1:0] {
        CMD_READ16  = 2'b00,
        CMD_WRITE8  = 2'b01,
        CMD_WRITE16 = 2'b10,
        CMD_RSVD    = 2'b11
    } cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        HEADER,
        ADDR,
        DATA,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_WAIT,
        RX_START,
        RX_DATA
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           cnt;
    logic                 err_set;

    cmd_t                 cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [15:0]          wdata;
    logic [15:0]          rdata;
    logic [ADDR_BITS-1:0] addr_hold;
    logic [7:0]           wdata_hold;
    logic [7:0]           data_last;
    logic                 tx_active;

    assign addr_inc  = addr + ADDR_ONE;
    assign data_last = (cmd == CMD_WRITE8) ? 8'd3 : 8'd7;
    assign tx_active = (tx_pins != 2'b00);

    // Control state: state, per-state cycle counter, error flag and the
    // registers that keep mem_addr/mem_wdata stable between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            protocol_error <= 1'b0;
            addr_hold      <= '0;
            wdata_hold     <= 8'd0;
        end else begin
            state <= state_nxt;
            // The counter restarts on every state change so each multi-cycle
            // state counts from zero.
            cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            if (err_set) begin
                protocol_error <= 1'b1;
            end
            if (mem_we || mem_re) begin
                addr_hold <= mem_addr;
            end
            if (mem_we) begin
                wdata_hold <= mem_wdata;
            end
        end
    end

    // Message datapath: header, address, write data and read result.
    always_ff @(posedge clk) begin
        case (state)
            HEADER:  cmd <= cmd_t'(tx_pins);
            // Shifting in at the top leaves pair 0 in addr[1:0] after the
            // last address cycle.
            ADDR:    addr <= {tx_pins, addr[ADDR_BITS-1:NSHIFT]};
            DATA:    wdata[{cnt[2:0], 1'b0} +: 2] <= tx_pins;
            RD_HI:   rdata[7:0] <= mem_rdata;
            // Only the first wait cycle carries the high byte from RD_HI.
            RD_WAIT: if (cnt == 8'd0) rdata[15:8] <= mem_rdata;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        rx_pins   = 2'b00;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (tx_pins[0]) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                state_nxt = ADDR;
            end
            ADDR: begin
                if (cnt == ADDR_LAST) begin
                    case (cmd)
                        CMD_READ16:  state_nxt = RD_LO;
                        CMD_WRITE8:  state_nxt = DATA;
                        CMD_WRITE16: state_nxt = DATA;
                        default: begin
                            state_nxt = IDLE;
                            err_set   = 1'b1;
                        end
                    endcase
                end
            end
            DATA: begin
                if (cnt == data_last) begin
                    state_nxt = WR_LO;
                end
            end
            WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = addr;
                mem_wdata = wdata[7:0];
                err_set   = tx_active;
                state_nxt = (cmd == CMD_WRITE16) ? WR_HI : IDLE;
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = addr_inc;
                mem_wdata = wdata[15:8];
                state_nxt = IDLE;
            end
            RD_LO: begin
                mem_re    = 1'b1;
                mem_addr  = addr;
                err_set   = tx_active;
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_re    = 1'b1;
                mem_addr  = addr_inc;
                err_set   = tx_active;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                err_set = tx_active;
                if (cnt == WAIT_LAST) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                rx_pins   = 2'b01;
                err_set   = tx_active;
                state_nxt = RX_DATA;
            end
            RX_DATA: begin
                rx_pins = rdata[{cnt[2:0], 1'b0} +: 2];
                err_set = tx_active;
                if (cnt == 8'd7) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_serial_responder.sv
`timescale 1ns/1ps
module tb_mem_serial_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  tx_pins;
    logic [1:0]  rx0, rx3;
    logic [15:0] addr0, addr3;
    logic [7:0]  wd0, wd3, rd0, rd3;
    logic        we0, we3, re0, re3, busy0, busy3, perr0, perr3;

    always #5 clk = ~clk;

    mem_serial_responder #(.ADDR_BITS(16), .NSHIFT(2), .RESP_DELAY(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_pins(tx_pins), .rx_pins(rx0),
        .mem_addr(addr0), .mem_wdata(wd0), .mem_we(we0), .mem_re(re0),
        .mem_rdata(rd0), .busy(busy0), .protocol_error(perr0));

    mem_serial_responder #(.ADDR_BITS(16), .NSHIFT(2), .RESP_DELAY(3)) u_dut3 (
        .clk(clk), .reset(reset), .tx_pins(tx_pins), .rx_pins(rx3),
        .mem_addr(addr3), .mem_wdata(wd3), .mem_we(we3), .mem_re(re3),
        .mem_rdata(rd3), .busy(busy3), .protocol_error(perr3));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Background memory contents: a fixed function of the address.
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Bench memories, one per DUT.
    bit         m0v[65536];
    logic [7:0] m0 [65536];
    bit         m3v[65536];
    logic [7:0] m3 [65536];

    always @(posedge clk) begin
        if (we0) begin m0[addr0] <= wd0; m0v[addr0] <= 1'b1; end
        if (re0) rd0 <= m0v[addr0] ? m0[addr0] : init_byte(addr0);
        if (we3) begin m3[addr3] <= wd3; m3v[addr3] <= 1'b1; end
        if (re3) rd3 <= m3v[addr3] ? m3[addr3] : init_byte(addr3);
    end

    // Reference model: expected memory contents and expected bus events.
    bit         ref_v[65536];
    logic [7:0] ref_m[65536];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_v[a] ? ref_m[a] : init_byte(a);
    endfunction

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    typedef struct {
        int          a_cyc;
        logic [15:0] word;
    } rxe_t;

    acc_t exp_acc[$];
    rxe_t exp_rx[$];
    bit   exp_perr = 1'b0;

    int          acc_idx[2];
    int          rx_idx[2];
    bit          rx_in[2];
    int          rx_cnt[2];
    int          rx_start[2];
    logic [1:0]  rx_sval[2];
    logic [15:0] rx_word[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic acc_step(input int d, input logic we, input logic re,
                            input logic [15:0] a, input logic [7:0] wd);
        acc_t e;
        if (!(we || re)) return;
        check($sformatf("we_re_excl%0d", d), 32'(we & re), 32'd0);
        if (acc_idx[d] >= exp_acc.size()) begin
            check($sformatf("acc_extra%0d", d), 32'(acc_idx[d] + 1), 32'(exp_acc.size()));
            return;
        end
        e = exp_acc[acc_idx[d]];
        acc_idx[d]++;
        check($sformatf("acc_cyc%0d", d), cyc, e.cyc);
        check($sformatf("acc_we%0d", d), 32'(we), 32'(e.wr));
        check($sformatf("acc_addr%0d", d), 32'(a), 32'(e.addr));
        if (e.wr) check($sformatf("acc_wdata%0d", d), 32'(wd), 32'(e.data));
    endtask

    task automatic rx_step(input int d, input logic [1:0] p);
        rxe_t e;
        if (!rx_in[d]) begin
            if (p != 2'b00) begin
                rx_in[d]    = 1'b1;
                rx_cnt[d]   = 0;
                rx_word[d]  = 16'h0;
                rx_start[d] = cyc;
                rx_sval[d]  = p;
            end
        end else begin
            rx_word[d][2*rx_cnt[d] +: 2] = p;
            rx_cnt[d]++;
            if (rx_cnt[d] == 8) begin
                rx_in[d] = 1'b0;
                if (rx_idx[d] >= exp_rx.size()) begin
                    check($sformatf("rx_extra%0d", d), 32'(rx_idx[d] + 1), 32'(exp_rx.size()));
                end else begin
                    e = exp_rx[rx_idx[d]];
                    rx_idx[d]++;
                    check($sformatf("rx_start_cyc%0d", d), rx_start[d], e.a_cyc + 4 + (d == 1 ? 3 : 0));
                    check($sformatf("rx_start_val%0d", d), 32'(rx_sval[d]), 32'd1);
                    check($sformatf("rx_word%0d", d), 32'(rx_word[d]), 32'(e.word));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            acc_step(0, we0, re0, addr0, wd0);
            acc_step(1, we3, re3, addr3, wd3);
            rx_step(0, rx0);
            rx_step(1, rx3);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [1:0] v);
        @(posedge clk);
        #1;
        tx_pins = v;
    endtask

    task automatic idle_until(input int s);
        while (cyc + 1 < s) drive(2'b00);
    endtask

    task automatic shift_in(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) drive(v[2*k +: 2]);
    endtask

    task automatic send_body(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] d,
                             output int ac, output int dc);
        drive(2'b01);
        drive(cmd);
        shift_in(a, 8);
        ac = cyc;
        if (cmd == 2'b01) shift_in(d, 4);
        else if (cmd == 2'b10) shift_in(d, 8);
        dc = cyc;
    endtask

    task automatic push_acc(input int c, input bit wr, input logic [15:0] a, input logic [7:0] v);
        acc_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.data = v;
        exp_acc.push_back(e);
        if (wr) begin ref_v[a] = 1'b1; ref_m[a] = v; end
    endtask

    task automatic expect_msg(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] d,
                              input int ac, input int dc, input bit lo_only, output int nxt);
        rxe_t r;
        logic [15:0] a1;
        a1 = a + 16'd1;
        case (cmd)
            2'b00: begin
                push_acc(ac + 1, 1'b0, a, 8'h00);
                push_acc(ac + 2, 1'b0, a1, 8'h00);
                r.a_cyc = ac;
                r.word  = {ref_rd(a1), ref_rd(a)};
                exp_rx.push_back(r);
                nxt = ac + 16;
            end
            2'b01: begin
                push_acc(dc + 1, 1'b1, a, d[7:0]);
                nxt = dc + 2;
            end
            2'b10: begin
                push_acc(dc + 1, 1'b1, a, d[7:0]);
                if (!lo_only) push_acc(dc + 2, 1'b1, a1, d[15:8]);
                nxt = dc + 3;
            end
            default: begin
                exp_perr = 1'b1;
                nxt = ac + 1;
            end
        endcase
    endtask

    task automatic send(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] tail, output int ac, output int nxt);
        int dc;
        send_body(cmd, a, d, ac, dc);
        expect_msg(cmd, a, d, ac, dc, 1'b0, nxt);
        drive(tail);
        if (tail != 2'b00) begin
            exp_perr = 1'b1;
            drive(2'b00);
        end
    endtask

    task automatic check_perr();
        check("perr0", 32'(perr0), 32'(exp_perr));
        check("perr3", 32'(perr3), 32'(exp_perr));
    endtask

    task automatic rst_outs();
        check("rst_rx0", 32'(rx0), 32'd0);     check("rst_rx3", 32'(rx3), 32'd0);
        check("rst_we0", 32'(we0), 32'd0);     check("rst_we3", 32'(we3), 32'd0);
        check("rst_re0", 32'(re0), 32'd0);     check("rst_re3", 32'(re3), 32'd0);
        check("rst_addr0", 32'(addr0), 32'd0); check("rst_addr3", 32'(addr3), 32'd0);
        check("rst_wd0", 32'(wd0), 32'd0);     check("rst_wd3", 32'(wd3), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0); check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_perr0", 32'(perr0), 32'd0); check("rst_perr3", 32'(perr3), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        tx_pins = 2'b00;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
        rst_outs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ac, dc, nxt;
        logic [1:0]  cmd;
        logic [15:0] ra, rd;
        int r;

        reset   = 1'b1;
        tx_pins = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        rst_outs();

        // WRITE_8 0x1234 <- 0xA5
        send(2'b01, 16'h1234, 16'h00A5, 2'b00, ac, nxt);
        @(negedge clk);
        check("w8_busy_wr", 32'(busy0), 32'd1);
        drive(2'b00);
        @(negedge clk);
        check("w8_busy_after", 32'(busy0), 32'd0);
        check("w8_busy_after3", 32'(busy3), 32'd0);
        check("w8_addr_hold", 32'(addr0), 32'h1234);
        check("w8_wdata_hold", 32'(wd0), 32'hA5);

        // WRITE_16 0xFFFF <- 0xBEEF, high byte wraps to 0x0000
        idle_until(nxt);
        send(2'b10, 16'hFFFF, 16'hBEEF, 2'b00, ac, nxt);
        @(negedge clk);
        check("w16_lo_addr", 32'(addr0), 32'hFFFF);
        check("w16_lo_data", 32'(wd0), 32'hEF);
        drive(2'b00);
        @(negedge clk);
        check("w16_hi_we", 32'(we0), 32'd1);
        check("w16_hi_addr", 32'(addr0), 32'h0000);
        check("w16_hi_data", 32'(wd0), 32'hBE);

        // Back-to-back write then READ_16 of 0x0100 holding 0x1234
        idle_until(nxt);
        send(2'b10, 16'h0100, 16'h1234, 2'b00, ac, nxt);
        idle_until(nxt);
        send(2'b00, 16'h0100, 16'h0000, 2'b00, ac, nxt);
        idle_until(nxt);

        // Stray start during RX_DATA (RD_WAIT for the delayed instance)
        send(2'b00, 16'h2468, 16'h0000, 2'b00, ac, nxt);
        idle_until(ac + 6);
        drive(2'b01);
        exp_perr = 1'b1;
        drive(2'b00);
        idle_until(nxt);
        check_perr();
        do_reset();

        // Reserved header: address consumed, no access, error flagged
        send(2'b11, 16'h5555, 16'h0000, 2'b00, ac, nxt);
        idle_until(nxt + 2);
        check_perr();
        check("rsvd_busy", 32'(busy0), 32'd0);

        // Reset in the middle of a write's address phase
        drive(2'b01); drive(2'b01); drive(2'b11); drive(2'b10);
        do_reset();
        repeat (20) drive(2'b00);

        // Reset while the low byte of a WRITE_16 is being written
        send_body(2'b10, 16'h3000, 16'hCAFE, ac, dc);
        expect_msg(2'b10, 16'h3000, 16'hCAFE, ac, dc, 1'b1, nxt);
        @(posedge clk); #1;
        tx_pins = 2'b00;
        reset   = 1'b1;
        @(negedge clk);
        check("rstwr_we", 32'(we0), 32'd1);
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
        rst_outs();
        repeat (5) drive(2'b00);

        // Stray start during WR_LO of a WRITE_8
        send(2'b01, 16'h4000, 16'h0077, 2'b01, ac, nxt);
        idle_until(nxt + 1);
        check_perr();
        do_reset();
        nxt = cyc + 1;

        // Randomized message stream
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            cmd = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ra = 16'($urandom);
            rd = 16'($urandom);
            idle_until(nxt + int'($urandom_range(0, 2)));
            check_perr();
            send(cmd, ra, rd, 2'b00, ac, nxt);
        end
        idle_until(nxt + 30);

        check("acc_count0", 32'(acc_idx[0]), 32'(exp_acc.size()));
        check("acc_count3", 32'(acc_idx[1]), 32'(exp_acc.size()));
        check("rx_count0", 32'(rx_idx[0]), 32'(exp_rx.size()));
        check("rx_count3", 32'(rx_idx[1]), 32'(exp_rx.size()));
        check_perr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
